multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the 16-bit RISC datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/risc_pkg.sv | 26 ++
 rtl/multicycle_sequencer_if.sv | 10 +
 rtl/multicycle_sequencer_mem_wait_timer.sv | 23 ++
 rtl/multicycle_sequencer.sv | 111 +++++++++++
 tb/tb_multicycle_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC sequencer: state encodings,
// opcode constants and the ALU-class opcode test.
package risc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd10;
  localparam logic [3:0] OP_BNE   = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !(op == OP_LOAD || op == OP_STORE || op == OP_BEQ ||
             op == OP_BNE  || op == OP_JMP);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port: request/ack handshake plus access attributes.
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts unacknowledged memory-request cycles; expired fires on the cycle the
// count would reach TIMEOUT without an ack.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && !clear && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC datapath; owns the
// memory handshake and every state-changing datapath strobe.
module multicycle_sequencer
  import risc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_sequencer_if.master bus,
  input  logic                  run,
  input  logic [3:0]            opcode,
  input  logic                  zero,
  output logic                  ir_load,
  output logic                  pc_inc,
  output logic                  pc_branch,
  output logic                  pc_jump,
  output logic                  rf_we,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      instr_count
);
  state_t state_q, state_d;
  logic   retire;
  logic   waiting;
  logic   expired;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  // Counter is held clear outside FETCH/MEM, so it always starts from zero there.
  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting || bus.mem_ack),
    .enable  (waiting && !bus.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    ir_load          = 1'b0;
    pc_inc           = 1'b0;
    pc_branch        = 1'b0;
    pc_jump          = 1'b0;
    rf_we            = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEM;
        end else if (is_alu_op(opcode)) begin
          state_d = S_WB;
        end else begin
          pc_branch = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
          pc_jump   = (opcode == OP_JMP);
          retire    = 1'b1;
        end
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (opcode == OP_STORE);
        if (bus.mem_ack) begin
          if (opcode == OP_STORE) retire  = 1'b1;
          else                    state_d = S_WB;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  assign state = state_q;
  assign busy  = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                 (state_q == S_MEM)   || (state_q == S_WB);
  assign err   = (state_q == S_ERR);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces built from the
// instruction-class rules, with randomized opcodes, flags, memory waits and run.
module tb_multicycle_sequencer;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       ir_load, pc_inc, pc_branch, pc_jump, rf_we, busy, err;
  logic [2:0] state;
  logic [1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit running = 0;
  logic [13:0] q[$];

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .run(run), .opcode(opcode), .zero(zero),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .rf_we(rf_we), .busy(busy), .err(err), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ev(int st, bit req, bit we, bit asel, bit irl, bit pci,
                                     bit br, bit jmp, bit rfwe);
    bit b = (st >= 1 && st <= 5);
    bit e = (st == 6);
    return {3'(st), req, we, asel, irl, pci, br, jmp, rfwe, b, e};
  endfunction

  function automatic logic [12:0] obs();
    return {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_load, pc_inc,
            pc_branch, pc_jump, rf_we, busy, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b1;
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_idle actual=%b required=%b", obs(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step();
    running = 1;
  endtask

  // wf/wm = unacked cycles before ack in FETCH/MEM; >= TO means the access times out.
  task automatic run_instr(input logic [3:0] op, input bit z, input int wf, input int wm,
                           input bit run_next);
    bit to = 0;
    bit is_mem = (op == 0 || op == 1);
    bit has_wb = !(op == 1 || op == 10 || op == 11 || op == 12);
    q.delete();
    for (int i = 0; i < (wf >= TO ? TO : wf); i++) q.push_back({1'b0, ev(1, 1, 0, 0, 0, 0, 0, 0, 0)});
    if (wf >= TO) begin
      to = 1;
    end else begin
      q.push_back({1'b1, ev(1, 1, 0, 0, 1, 1, 0, 0, 0)});
      q.push_back({1'($urandom_range(0, 1)), ev(2, 0, 0, 0, 0, 0, 0, 0, 0)});
      q.push_back({1'($urandom_range(0, 1)), ev(3, 0, 0, 0, 0, 0,
                   (op == 10 && z) || (op == 11 && !z), op == 12, 0)});
      if (is_mem) begin
        for (int i = 0; i < (wm >= TO ? TO : wm); i++)
          q.push_back({1'b0, ev(4, 1, op == 1, 1, 0, 0, 0, 0, 0)});
        if (wm >= TO) to = 1;
        else q.push_back({1'b1, ev(4, 1, op == 1, 1, 0, 0, 0, 0, 0)});
      end
      if (has_wb && !to) q.push_back({1'($urandom_range(0, 1)), ev(5, 0, 0, 0, 0, 0, 0, 0, 1)});
    end
    if (to) begin
      for (int i = 0; i < 3; i++) q.push_back({1'($urandom_range(0, 1)), ev(6, 0, 0, 0, 0, 0, 0, 0, 0)});
    end
    opcode = op;
    zero = z;
    run = run_next;
    foreach (q[i]) begin
      bus.mem_ack = q[i][13];
      @(negedge clk);
      checks++;
      if (obs() !== q[i][12:0]) begin
        errors++;
        $display("FAIL trace op=%0d z=%0b wf=%0d wm=%0d cyc=%0d actual=%b required=%b",
                 op, z, wf, wm, i, obs(), q[i][12:0]);
      end
      step();
    end
    bus.mem_ack = 1'b0;
    if (!to) exp_count = (exp_count + 1) % 4;
    running = run_next && !to;
    checks++;
    if (instr_count !== 2'(exp_count)) begin
      errors++;
      $display("FAIL instr_count op=%0d actual=%0d required=%0d", op, instr_count, exp_count);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    #1;
    exp_count = 0;
    running = 0;
    checks++;
    if ({obs(), instr_count} !== {ev(0, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0}) begin
      errors++;
      $display("FAIL reset_state actual=%b/%0d required=%b/0", obs(), instr_count,
               ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem_ack = 1'b0;
    opcode = 4'd0;
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs() !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL idle_hold actual=%b required=%b", obs(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      step();
    end
  endtask

  task automatic test_alu();
    int ops[11] = '{2, 3, 4, 5, 6, 7, 8, 9, 13, 14, 15};
    start_run();
    run_instr(4'(ops[$urandom_range(0, 10)]), 1'($urandom_range(0, 1)), 0, 0, 1);
  endtask

  task automatic test_load_wait();
    run_instr(4'd0, 1'b0, 0, 2, 1);
    run_instr(4'd0, 1'b1, 3, 3, 1);
  endtask

  task automatic test_store_branch_jump();
    run_instr(4'd1, 1'b0, 0, 0, 1);
    run_instr(4'd10, 1'b1, 0, 0, 1);
    run_instr(4'd10, 1'b0, 1, 0, 1);
    run_instr(4'd11, 1'b1, 0, 0, 1);
    run_instr(4'd11, 1'b0, 0, 0, 1);
    run_instr(4'd12, 1'($urandom_range(0, 1)), 2, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      if (!running) start_run();
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) < 7);
    end
  endtask

  task automatic test_run_drop();
    if (!running) start_run();
    run_instr(4'd0, 1'b0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL idle_after_drop actual=%b required=%b", obs(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      step();
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    start_run();
    run_instr(4'd2, 1'b0, TO, 0, 1);
    do_reset();
    start_run();
    run_instr(4'd0, 1'b0, 0, TO, 1);
    do_reset();
  endtask

  task automatic test_rst_mid_mem();
    opcode = 4'd0;
    run = 1'b1;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== ev(4, 1, 0, 1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL in_mem actual=%b required=%b", obs(), ev(4, 1, 0, 1, 0, 0, 0, 0, 0));
    end
    #2;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_branch_jump();
    test_back_to_back();
    test_run_drop();
    test_timeout();
    test_rst_mid_mem();
    start_run();
    for (int n = 0; n < 5; n++) run_instr(4'd13, 1'b0, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
